// File: rtl/ctu_clsp_cken_seq.sv
// Clock-enable release sequencer for the jbus cluster.
// After start_clk_jl rises, channel clock enables are released one at a time,
// STAGGER cycles apart, starting at channel 0. Dropping start_clk_jl or
// asserting reset returns every channel to its DFLT_ON value. A separate,
// always-running trigger path registers tr_in and produces rising-edge pulses
// and an any-bit summary.
module ctu_clsp_cken_seq #(
  parameter int             NCH     = 8,
  parameter int             STAGGER = 4,
  parameter int             NTR     = 5,
  parameter logic [NCH-1:0] DFLT_ON = NCH'(8'hF0)
) (
  input  logic           jbus_clk,
  input  logic           jbus_rst,
  input  logic           start_clk_jl,
  input  logic [NCH-1:0] cken_pre_jl,
  input  logic [NTR-1:0] tr_in,
  output logic [NCH-1:0] cken_jl,
  output logic           seq_busy,
  output logic           seq_done,
  output logic [NTR-1:0] tr_jl,
  output logic [NTR-1:0] tr_rise_jl,
  output logic           tr_any_jl
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [NCH-1:0]   rel;
  logic [NCH-1:0]   rel_nx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             done_nx;
  logic [NCH-1:0]   cken_nx;

  // Next-state logic: start, step through channels, or abort on start drop.
  always_comb begin
    state_nx = state;
    rel_nx   = rel;
    idx_nx   = idx;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    if (!start_clk_jl) begin
      // A low start level cancels any sequence in progress without a done pulse.
      state_nx = ST_IDLE;
      rel_nx   = '0;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_SEQ;
          rel_nx   = NCH'(1);
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        ST_SEQ: begin
          if (cnt == CNT_LAST) begin
            if (idx == IDX_LAST) begin
              state_nx = ST_RUN;
              done_nx  = 1'b1;
            end else begin
              // Released channels form a contiguous run from bit 0, so a
              // shift-and-OR sets exactly bit idx+1.
              rel_nx = rel | (rel << 1);
              idx_nx = idx + IDX_W'(1);
              cnt_nx = '0;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state_nx = ST_RUN;
        end
        default: begin
          state_nx = ST_IDLE;
          rel_nx   = '0;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Channel enable selection: defaults while stopped, gated pre-enables otherwise.
  always_comb begin
    cken_nx = DFLT_ON;
    if (start_clk_jl) begin
      cken_nx = rel & cken_pre_jl;
    end
  end

  // Sequencer and enable registers.
  always_ff @(posedge jbus_clk) begin
    if (jbus_rst) begin
      state    <= ST_IDLE;
      rel      <= '0;
      idx      <= '0;
      cnt      <= '0;
      cken_jl  <= DFLT_ON;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nx;
      rel      <= rel_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      cken_jl  <= cken_nx;
      seq_done <= done_nx;
    end
  end

  assign seq_busy = (state == ST_SEQ);

  // Trigger path: synchronise, detect rising edges, summarise; ignores the sequencer.
  always_ff @(posedge jbus_clk) begin
    if (jbus_rst) begin
      tr_jl      <= '0;
      tr_rise_jl <= '0;
      tr_any_jl  <= 1'b0;
    end else begin
      tr_jl      <= tr_in;
      tr_rise_jl <= tr_in & ~tr_jl;
      tr_any_jl  <= |tr_in;
    end
  end

endmodule
